// File: rtl/dtg_timing.sv
// dtg_timing: display timing generator for the VGA path.
//
// Two free-running 12-bit counters walk the raster: pixel_column over
// 0..H_TOTAL-1 and pixel_row over 0..V_TOTAL-1. From these it derives
// the sync pulses, the visible-area enable and a start-of-frame pulse.
// Every output is a register loaded from the *next* counter values. As a
// result, all outputs describe the coordinate currently on
// pixel_row/pixel_column, and there is no skew between outputs.
//
// Ports:
//   clk           pixel clock
//   rst_n         synchronous active-low reset
//   pix_ce        pixel clock enable (only when DTG_PIXCE_EN is defined)
//   horiz_sync    horizontal sync, asserted level = SYNC_POL
//   vert_sync     vertical sync, asserted level = SYNC_POL
//   video_on      high while the current coordinate is in the visible area
//   pixel_row     current line, 0..V_TOTAL-1
//   pixel_column  current pixel in line, 0..H_TOTAL-1
//   frame_start   high while the current coordinate is (0,0)
//
// Optional build macro:
//   DTG_PIXCE_EN  adds the pix_ce input. Counters and outputs advance only
//                 on edges where pix_ce=1 and hold otherwise. Reset does
//                 not depend on pix_ce.
//
// Reset parks the counters at the last coordinate of the frame. The first
// edge after reset is released therefore presents (0,0).
module dtg_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DTG_PIXCE_EN
  input  logic        pix_ce,
`endif
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic [11:0] pixel_row,
  output logic [11:0] pixel_column,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Window bounds are held at 13 bits so that a total of exactly 4096
  // does not wrap the upper bound to zero.
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic        adv;
  logic [11:0] col_nxt;
  logic [11:0] row_nxt;
  logic [12:0] col_ext;
  logic [12:0] row_ext;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        vo_nxt;
  logic        fs_nxt;

`ifdef DTG_PIXCE_EN
  assign adv = pix_ce;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    col_nxt = pixel_column + 12'd1;
    row_nxt = pixel_row;
    if (pixel_column == H_LAST) begin
      col_nxt = 12'd0;
      // The row advances, or wraps, on the same edge as the column wrap.
      row_nxt = (pixel_row == V_LAST) ? 12'd0 : pixel_row + 12'd1;
    end

    col_ext = {1'b0, col_nxt};
    row_ext = {1'b0, row_nxt};

    vo_nxt = (col_ext < H_ACT_END) && (row_ext < V_ACT_END);
    hs_nxt = ((col_ext >= H_SYNC_BEG) && (col_ext < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt = ((row_ext >= V_SYNC_BEG) && (row_ext < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    fs_nxt = (col_nxt == 12'd0) && (row_nxt == 12'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_column <= H_LAST;
      pixel_row    <= V_LAST;
      video_on     <= 1'b0;
      frame_start  <= 1'b0;
      horiz_sync   <= ~SYNC_POL;
      vert_sync    <= ~SYNC_POL;
    end else if (adv) begin
      pixel_column <= col_nxt;
      pixel_row    <= row_nxt;
      video_on     <= vo_nxt;
      frame_start  <= fs_nxt;
      horiz_sync   <= hs_nxt;
      vert_sync    <= vs_nxt;
    end
  end

endmodule

// File: tb/tb_dtg_timing.sv
// Testbench for dtg_timing.
//
// Two instances run from the same clock and reset:
//   u_def    default 640x480 timing, active-low syncs
//   u_small  32x20 raster with active-high syncs, so that whole frames fit
//            in a short run
//             H: 16 active, 4 fp, 6 sync (cols 20..25), 6 bp
//             V: 12 active, 2 fp, 2 sync (rows 14..15), 4 bp
//
// Edge k is the k-th rising edge after reset is released, counting from 0.
// That edge presents col = k mod H_TOTAL, row = (k div H_TOTAL) mod V_TOTAL.
module tb_dtg_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b1;

  logic        d_hs, d_vs, d_vo, d_fs;
  logic [11:0] d_row, d_col;
  logic        s_hs, s_vs, s_vo, s_fs;
  logic [11:0] s_row, s_col;

  always #5 clk = ~clk;

  dtg_timing u_def (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef DTG_PIXCE_EN
    .pix_ce       (pix_ce),
`endif
    .horiz_sync   (d_hs),
    .vert_sync    (d_vs),
    .video_on     (d_vo),
    .pixel_row    (d_row),
    .pixel_column (d_col),
    .frame_start  (d_fs)
  );

  dtg_timing #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .SYNC_POL(1'b1)
  ) u_small (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef DTG_PIXCE_EN
    .pix_ce       (pix_ce),
`endif
    .horiz_sync   (s_hs),
    .vert_sync    (s_vs),
    .video_on     (s_vo),
    .pixel_row    (s_row),
    .pixel_column (s_col),
    .frame_start  (s_fs)
  );

  typedef struct {
    int sml;  // 0 = u_def, 1 = u_small
    int k;
    int col;
    int row;
    int vo;
    int hs;
    int vs;
    int fs;
  } vec_t;

  vec_t vecs[28];

  int total = 0;
  int bad = 0;
  int kk = -1;

  int d_hs_cnt = 0, d_vo_cnt = 0, d_fs_cnt = 0;
  int s_hs_cnt = 0, s_vs_cnt = 0, s_fs_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to edge k, sampling 1 time unit after each edge. The counters
  // accumulate asserted cycles over every sampled edge.
  task automatic advance_to(input int k);
    while (kk < k) begin
      @(posedge clk);
      kk++;
      #1;
      d_hs_cnt += (d_hs == 1'b0) ? 1 : 0;
      d_vo_cnt += (d_vo == 1'b1) ? 1 : 0;
      d_fs_cnt += (d_fs == 1'b1) ? 1 : 0;
      s_hs_cnt += (s_hs == 1'b1) ? 1 : 0;
      s_vs_cnt += (s_vs == 1'b1) ? 1 : 0;
      s_fs_cnt += (s_fs == 1'b1) ? 1 : 0;
    end
  endtask

  task automatic chk_all(input string tag, input int sml, input int col, input int row,
                         input int vo, input int hs, input int vs, input int fs);
    if (sml == 0) begin
      chk({tag, " def col"}, int'(d_col), col);
      chk({tag, " def row"}, int'(d_row), row);
      chk({tag, " def video_on"}, int'(d_vo), vo);
      chk({tag, " def hsync"}, int'(d_hs), hs);
      chk({tag, " def vsync"}, int'(d_vs), vs);
      chk({tag, " def frame_start"}, int'(d_fs), fs);
    end else begin
      chk({tag, " small col"}, int'(s_col), col);
      chk({tag, " small row"}, int'(s_row), row);
      chk({tag, " small video_on"}, int'(s_vo), vo);
      chk({tag, " small hsync"}, int'(s_hs), hs);
      chk({tag, " small vsync"}, int'(s_vs), vs);
      chk({tag, " small frame_start"}, int'(s_fs), fs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           sml  k    col  row vo hs vs fs
    vecs[0]  = '{0,   0,   0,   0,  1, 1, 1, 1};
    vecs[1]  = '{1,   0,   0,   0,  1, 0, 0, 1};
    vecs[2]  = '{0,   1,   1,   0,  1, 1, 1, 0};
    vecs[3]  = '{1,   15,  15,  0,  1, 0, 0, 0};
    vecs[4]  = '{1,   16,  16,  0,  0, 0, 0, 0};
    vecs[5]  = '{1,   19,  19,  0,  0, 0, 0, 0};
    vecs[6]  = '{1,   20,  20,  0,  0, 1, 0, 0};
    vecs[7]  = '{1,   25,  25,  0,  0, 1, 0, 0};
    vecs[8]  = '{1,   26,  26,  0,  0, 0, 0, 0};
    vecs[9]  = '{1,   31,  31,  0,  0, 0, 0, 0};
    vecs[10] = '{1,   32,  0,   1,  1, 0, 0, 0};
    vecs[11] = '{1,   367, 15,  11, 1, 0, 0, 0};
    vecs[12] = '{1,   384, 0,   12, 0, 0, 0, 0};
    vecs[13] = '{1,   447, 31,  13, 0, 0, 0, 0};
    vecs[14] = '{1,   448, 0,   14, 0, 0, 1, 0};
    vecs[15] = '{1,   511, 31,  15, 0, 0, 1, 0};
    vecs[16] = '{1,   512, 0,   16, 0, 0, 0, 0};
    vecs[17] = '{0,   639, 639, 0,  1, 1, 1, 0};
    vecs[18] = '{1,   639, 31,  19, 0, 0, 0, 0};
    vecs[19] = '{0,   640, 640, 0,  0, 1, 1, 0};
    vecs[20] = '{1,   640, 0,   0,  1, 0, 0, 1};
    vecs[21] = '{1,   641, 1,   0,  1, 0, 0, 0};
    vecs[22] = '{0,   655, 655, 0,  0, 1, 1, 0};
    vecs[23] = '{0,   656, 656, 0,  0, 0, 1, 0};
    vecs[24] = '{0,   751, 751, 0,  0, 0, 1, 0};
    vecs[25] = '{0,   752, 752, 0,  0, 1, 1, 0};
    vecs[26] = '{0,   799, 799, 0,  0, 1, 1, 0};
    vecs[27] = '{0,   800, 0,   1,  1, 1, 1, 0};

    // Hold reset for 3 edges and check the parked values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 799, 524, 0, 1, 1, 0);
    chk_all("reset", 1, 31, 19, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      advance_to(vecs[i].k);
      chk_all($sformatf("vec%0d k=%0d", i, vecs[i].k), vecs[i].sml, vecs[i].col,
              vecs[i].row, vecs[i].vo, vecs[i].hs, vecs[i].vs, vecs[i].fs);
    end

    // Totals over edges 0..1279: two full small frames, plus row 0 and the
    // first 480 columns of row 1 for the default instance.
    advance_to(1279);
    chk("def hsync asserted cycles", d_hs_cnt, 96);
    chk("def video_on cycles", d_vo_cnt, 640 + 480);
    chk("def frame_start cycles", d_fs_cnt, 1);
    chk("small hsync asserted cycles", s_hs_cnt, 40 * 6);
    chk("small vsync asserted cycles", s_vs_cnt, 2 * 64);
    chk("small frame_start cycles", s_fs_cnt, 2);

    // Assert reset mid-frame. Edge 1450 is small (10,5) and default (650,1).
    advance_to(1450);
    chk_all("pre midreset", 1, 10, 5, 1, 0, 0, 0);
    chk_all("pre midreset", 0, 650, 1, 0, 1, 1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all("midreset", 0, 799, 524, 0, 1, 1, 0);
    chk_all("midreset", 1, 31, 19, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post midreset", 0, 0, 0, 1, 1, 1, 1);
    chk_all("post midreset", 1, 0, 0, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    chk_all("post midreset+1", 0, 1, 0, 1, 1, 1, 0);
    chk_all("post midreset+1", 1, 1, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
